// File: rtl/shared_shifter_scheduler_pkg.sv
// rtl/shared_shifter_scheduler_pkg.sv - shared types and constants for the shift scheduler
// Purpose: FSM state encoding, direction and requester-id constants.
// Ports: none (package).
package shift_sched_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic ID_A      = 1'b0;
  localparam logic ID_B      = 1'b1;

endpackage

// File: rtl/shared_shifter_scheduler_if.sv
// rtl/shared_shifter_scheduler_if.sv - request/result handshake bundle for the shift scheduler
// Purpose: groups both requester ports and the result port.
// Ports (master = clients/consumer side, slave = scheduler side):
//   a_vld/a_rdy/a_data/a_amt/a_dir  requester A
//   b_vld/b_rdy/b_data/b_amt/b_dir  requester B
//   res_vld/res_rdy/res_data/res_id result and its owner
interface shared_shifter_scheduler_if #(
  parameter int N  = 8,
  parameter int SW = 3
);

  logic          a_vld;
  logic          a_rdy;
  logic [N-1:0]  a_data;
  logic [SW-1:0] a_amt;
  logic          a_dir;

  logic          b_vld;
  logic          b_rdy;
  logic [N-1:0]  b_data;
  logic [SW-1:0] b_amt;
  logic          b_dir;

  logic          res_vld;
  logic          res_rdy;
  logic [N-1:0]  res_data;
  logic          res_id;

  modport master (
    output a_vld, a_data, a_amt, a_dir,
    output b_vld, b_data, b_amt, b_dir,
    output res_rdy,
    input  a_rdy, b_rdy, res_vld, res_data, res_id
  );

  modport slave (
    input  a_vld, a_data, a_amt, a_dir,
    input  b_vld, b_data, b_amt, b_dir,
    input  res_rdy,
    output a_rdy, b_rdy, res_vld, res_data, res_id
  );

endinterface

// File: rtl/shared_shifter_scheduler_rr_arbiter_2.sv
// rtl/shared_shifter_scheduler_rr_arbiter_2.sv - two-way round-robin arbiter
// Purpose: purely combinational; on contention the requester that was not granted last wins.
// Ports:
//   req[1:0]   requests (bit 0 = A, bit 1 = B)
//   last       id of the most recent grant
//   grant[1:0] one-hot grant, zero when nobody requests
module rr_arbiter_2
  import shift_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  assign grant[0] = req[0] & (~req[1] | (last == ID_B));
  assign grant[1] = req[1] & (~req[0] | (last == ID_A));

endmodule

// File: rtl/shared_shifter_scheduler.sv
// rtl/shared_shifter_scheduler.sv - one 1-bit-per-cycle logical shifter shared by two requesters
// Purpose: round-robin picks A or B, the operand is shifted one bit per cycle, and the
//   result is held until the consumer takes it.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of shared_shifter_scheduler_if (requests A/B, result)
module shared_shifter_scheduler
  import shift_sched_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  shared_shifter_scheduler_if.slave    bus
);

  state_t        state;
  logic [N-1:0]  shreg;
  logic [SW-1:0] cnt;
  logic          dir_q;
  logic          last;
  logic          id_q;
  logic          vld_q;

  logic [1:0]    req;
  logic [1:0]    grant;
  logic          take;
  logic          win;
  logic [N-1:0]  win_data;
  logic [SW-1:0] win_amt;
  logic          win_dir;

  assign req = {bus.b_vld, bus.a_vld};

  rr_arbiter_2 u_arb (
    .req   (req),
    .last  (last),
    .grant (grant)
  );

  // rdy is only offered in IDLE and is forced low while reset is held.
  assign take      = rst_n && (state == IDLE) && (|grant);
  assign bus.a_rdy = take & grant[0];
  assign bus.b_rdy = take & grant[1];

  assign win      = grant[1] ? ID_B : ID_A;
  assign win_data = grant[1] ? bus.b_data : bus.a_data;
  assign win_amt  = grant[1] ? bus.b_amt  : bus.a_amt;
  assign win_dir  = grant[1] ? bus.b_dir  : bus.a_dir;

  // The shift register doubles as the result register; it is only
  // observable as a result while res_vld is high.
  assign bus.res_data = shreg;
  assign bus.res_id   = id_q;
  assign bus.res_vld  = vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      dir_q <= DIR_LEFT;
      last  <= ID_B;
      id_q  <= ID_A;
      vld_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            shreg <= win_data;
            cnt   <= win_amt;
            dir_q <= win_dir;
            id_q  <= win;
            last  <= win;
            if (win_amt == '0) begin
              state <= DONE;
              vld_q <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          shreg <= (dir_q == DIR_LEFT) ? (shreg << 1) : (shreg >> 1);
          cnt   <= cnt - SW'(1);
          // The last shift cycle hands straight over to DONE, so res_vld
          // rises exactly amt cycles after the first shift cycle.
          if (cnt == SW'(1)) begin
            state <= DONE;
            vld_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.res_rdy) begin
            state <= IDLE;
            vld_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          vld_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_shifter_scheduler.sv
// tb/tb_shared_shifter_scheduler.sv - self-checking bench for shared_shifter_scheduler
module tb_shared_shifter_scheduler;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [7:0] op_d   [2][128];
  logic [2:0] op_amt [2][128];
  logic       op_dir [2][128];

  shared_shifter_scheduler_if #(.N(8), .SW(3)) bus ();

  shared_shifter_scheduler #(.N(8), .SW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] a, input logic dir);
    return dir ? (d >> a) : (d << a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input bit vld, input logic [7:0] d,
                         input logic [2:0] amt, input bit dir);
    if (id) begin
      bus.b_vld = vld; bus.b_data = d; bus.b_amt = amt; bus.b_dir = dir;
    end else begin
      bus.a_vld = vld; bus.a_data = d; bus.a_amt = amt; bus.a_dir = dir;
    end
  endtask

  // One operation from a single requester: checks grant, latency, result, owner.
  task automatic run_one(input bit id, input logic [7:0] d, input logic [2:0] amt,
                         input bit dir, input bit hand, input string tag);
    int k;
    int bad;
    set_req(id, 1'b1, d, amt, dir);
    #1;
    check({tag, "_rdy"}, 32'(id ? bus.b_rdy : bus.a_rdy), 32'd1);
    check({tag, "_other_rdy"}, 32'(id ? bus.a_rdy : bus.b_rdy), 32'd0);
    tick();
    set_req(id, 1'b1, ~d, ~amt, ~dir);
    k = 0;
    bad = 0;
    while (!bus.res_vld && k < 40) begin
      if (bus.a_rdy || bus.b_rdy) bad++;
      tick();
      k++;
    end
    if (bus.a_rdy || bus.b_rdy) bad++;
    set_req(id, 1'b0, 8'h00, 3'd0, 1'b0);
    check({tag, "_busy_rdy"}, 32'(bad), 32'd0);
    check({tag, "_lat"}, 32'(k), 32'(amt));
    check({tag, "_data"}, 32'(bus.res_data), 32'(ref_shift(d, amt, dir)));
    check({tag, "_id"}, 32'(bus.res_id), 32'(id));
    if (hand) begin
      bus.res_rdy = 1'b1;
      tick();
      bus.res_rdy = 1'b0;
      check({tag, "_vld_clr"}, 32'(bus.res_vld), 32'd0);
    end
  endtask

  // Both requesters stream n ops each from the op tables; in directed mode
  // grants must alternate starting with A, in random mode vld and res_rdy jitter.
  task automatic stream(input int n, input bit rnd, input string tag);
    int         idx [2];
    int         done_cnt;
    int         gi;
    logic [7:0] exp_d [$];
    bit         exp_id [$];
    idx[0] = 0; idx[1] = 0;
    done_cnt = 0;
    gi = 0;
    for (int cyc = 0; cyc < 20000 && done_cnt < 2 * n; cyc++) begin
      bus.res_rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bus.res_vld) begin
        if (exp_d.size() == 0) begin
          check({tag, "_spurious"}, 32'd1, 32'd0);
        end else begin
          check({tag, "_data"}, 32'(bus.res_data), 32'(exp_d[0]));
          check({tag, "_id"}, 32'(bus.res_id), 32'(exp_id[0]));
          if (bus.res_rdy) begin
            void'(exp_d.pop_front());
            void'(exp_id.pop_front());
            done_cnt++;
          end
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (idx[r] < n)
          set_req(r[0], rnd ? ($urandom_range(0, 1) == 1) : 1'b1,
                  op_d[r][idx[r]], op_amt[r][idx[r]], op_dir[r][idx[r]]);
        else
          set_req(r[0], 1'b0, 8'h00, 3'd0, 1'b0);
      end
      #1;
      if (bus.a_rdy && bus.b_rdy) check({tag, "_both_rdy"}, 32'd1, 32'd0);
      for (int r = 0; r < 2; r++) begin
        if ((r == 0) ? bus.a_rdy : bus.b_rdy) begin
          exp_d.push_back(ref_shift(op_d[r][idx[r]], op_amt[r][idx[r]], op_dir[r][idx[r]]));
          exp_id.push_back(r[0]);
          if (!rnd) begin
            check($sformatf("%s_grant%0d", tag, gi), 32'(r), 32'(gi % 2));
            gi++;
          end
          idx[r]++;
        end
      end
      tick();
    end
    set_req(1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    set_req(1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    bus.res_rdy = 1'b0;
    check({tag, "_count"}, 32'(done_cnt), 32'(2 * n));
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    set_req(1'b0, 1'b1, 8'hFF, 3'd1, 1'b0);
    set_req(1'b1, 1'b1, 8'hFF, 3'd1, 1'b0);
    bus.res_rdy = 1'b0;
    #12;
    check("rst_a_rdy", 32'(bus.a_rdy), 32'd0);
    check("rst_b_rdy", 32'(bus.b_rdy), 32'd0);
    check("rst_res_vld", 32'(bus.res_vld), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_res_id", 32'(bus.res_id), 32'd0);
    tick();
    set_req(1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    set_req(1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Directed single ops (expected 0xB0, 0x16, 0xA5, 0x01)
    run_one(1'b0, 8'b1011_0110, 3'd3, 1'b0, 1'b1, "t1");
    check("t1_hand", 32'(ref_shift(8'b1011_0110, 3'd3, 1'b0)), 32'h0000_00B0);
    run_one(1'b1, 8'b1011_0110, 3'd3, 1'b1, 1'b1, "t2");
    run_one(1'b0, 8'hA5, 3'd0, 1'b0, 1'b1, "t3a");
    run_one(1'b1, 8'hFF, 3'd7, 1'b1, 1'b1, "t3b");

    // Contention: last grant was B, so A must lead
    op_d[0][0] = 8'hC3; op_amt[0][0] = 3'd1; op_dir[0][0] = 1'b0;
    op_d[0][1] = 8'h3C; op_amt[0][1] = 3'd4; op_dir[0][1] = 1'b1;
    op_d[0][2] = 8'hFF; op_amt[0][2] = 3'd7; op_dir[0][2] = 1'b0;
    op_d[0][3] = 8'h81; op_amt[0][3] = 3'd0; op_dir[0][3] = 1'b1;
    op_d[1][0] = 8'h96; op_amt[1][0] = 3'd2; op_dir[1][0] = 1'b1;
    op_d[1][1] = 8'h0F; op_amt[1][1] = 3'd5; op_dir[1][1] = 1'b0;
    op_d[1][2] = 8'h80; op_amt[1][2] = 3'd6; op_dir[1][2] = 1'b1;
    op_d[1][3] = 8'h55; op_amt[1][3] = 3'd3; op_dir[1][3] = 1'b0;
    stream(4, 1'b0, "t4");

    // Stall in DONE: result stable, no grants, then exactly one transfer
    run_one(1'b0, 8'h3C, 3'd2, 1'b1, 1'b0, "t5");
    for (int i = 0; i < 5; i++) begin
      set_req(1'b0, 1'b1, 8'h11, 3'd1, 1'b0);
      set_req(1'b1, 1'b1, 8'h22, 3'd1, 1'b0);
      #1;
      check("t5_stall_rdy", 32'({bus.a_rdy, bus.b_rdy}), 32'd0);
      check("t5_stall_vld", 32'(bus.res_vld), 32'd1);
      check("t5_stall_data", 32'(bus.res_data), 32'h0F);
      check("t5_stall_id", 32'(bus.res_id), 32'd0);
      tick();
    end
    set_req(1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    set_req(1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    bus.res_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_one_xfer", 32'(bus.res_vld), 32'd0);
    end
    bus.res_rdy = 1'b0;

    // Reset mid-SHIFT (last grant is A here)
    set_req(1'b0, 1'b1, 8'hFF, 3'd7, 1'b0);
    #1;
    check("t6_rdy", 32'(bus.a_rdy), 32'd1);
    tick();
    set_req(1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    tick();
    tick();
    check("t6_pre_vld", 32'(bus.res_vld), 32'd0);
    rst_n = 1'b0;
    set_req(1'b0, 1'b1, 8'h81, 3'd1, 1'b1);
    set_req(1'b1, 1'b1, 8'h42, 3'd1, 1'b1);
    #1;
    check("t6_rst_vld", 32'(bus.res_vld), 32'd0);
    check("t6_rst_data", 32'(bus.res_data), 32'd0);
    check("t6_rst_rdy", 32'({bus.a_rdy, bus.b_rdy}), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("t6_a_first", 32'(bus.a_rdy), 32'd1);
    check("t6_b_wait", 32'(bus.b_rdy), 32'd0);
    set_req(1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    set_req(1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    tick();
    run_one(1'b0, 8'h81, 3'd1, 1'b1, 1'b1, "t6_after");

    // Reset mid-DONE
    run_one(1'b1, 8'h5A, 3'd0, 1'b0, 1'b0, "t6b");
    rst_n = 1'b0;
    #1;
    check("t6b_rst_vld", 32'(bus.res_vld), 32'd0);
    check("t6b_rst_data", 32'(bus.res_data), 32'd0);
    check("t6b_rst_id", 32'(bus.res_id), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Random traffic with stalls
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 100; i++) begin
        op_d[r][i]   = 8'($urandom);
        op_amt[r][i] = 3'($urandom_range(0, 7));
        op_dir[r][i] = 1'($urandom_range(0, 1));
      end
    end
    stream(100, 1'b1, "rnd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
